// File: rtl/multi_channel_output_buffer.sv
// Per-channel result FIFOs with hysteretic throttle flags, merged round-robin
// into a single valid/ready output register tagged with the source channel.
module multi_channel_output_buffer #(
  parameter int WIDTH      = 64,
  parameter int CHANNELS   = 4,
  parameter int DEPTH_LOG2 = 9,
  parameter int SLOW_HIGH  = 400,
  parameter int SLOW_LOW   = 256,
  localparam int CH_BITS   = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [CHANNELS-1:0]       dataInValid,
  input  logic [CHANNELS*WIDTH-1:0] dataIn,
  output logic [CHANNELS-1:0]       slowInputting,
  output logic [CHANNELS-1:0]       overflow,
  input  logic                      dataOutReady,
  output logic                      dataOutValid,
  output logic [WIDTH-1:0]          dataOut,
  output logic [CH_BITS-1:0]        dataOutChannel
);

  localparam int DEPTH = 2 ** DEPTH_LOG2;
  localparam int CNT_W = DEPTH_LOG2 + 1;
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0] HIGH_CNT = CNT_W'(SLOW_HIGH);
  localparam logic [CNT_W-1:0] LOW_CNT  = CNT_W'(SLOW_LOW);

  logic [WIDTH-1:0]      mem   [CHANNELS][DEPTH];
  logic [DEPTH_LOG2-1:0] wrPtr [CHANNELS];
  logic [DEPTH_LOG2-1:0] rdPtr [CHANNELS];
  logic [CNT_W-1:0]      count [CHANNELS];

  logic [CHANNELS-1:0] notEmpty;
  logic [CHANNELS-1:0] full;
  logic [CHANNELS-1:0] push;
  logic [CHANNELS-1:0] pop;
  logic [CH_BITS-1:0]  lastGrant;
  logic [CH_BITS-1:0]  grantCh;
  logic                grantValid;
  logic                loadOut;

  always_comb begin
    notEmpty = '0;
    full     = '0;
    push     = '0;
    for (int c = 0; c < CHANNELS; c++) begin
      notEmpty[c] = (count[c] != '0);
      full[c]     = (count[c] == FULL_CNT);
      push[c]     = dataInValid[c] && !full[c];
    end
  end

  // Scan starts one past the last grant and wraps, so every channel is visited once.
  always_comb begin
    int idx;
    idx        = 0;
    grantValid = 1'b0;
    grantCh    = '0;
    for (int k = 0; k < CHANNELS; k++) begin
      idx = int'(lastGrant) + 1 + k;
      if (idx >= CHANNELS) idx = idx - CHANNELS;
      if (!grantValid && notEmpty[idx]) begin
        grantValid = 1'b1;
        grantCh    = CH_BITS'(idx);
      end
    end
  end

  assign loadOut = (!dataOutValid || dataOutReady) && grantValid;

  always_comb begin
    pop = '0;
    for (int c = 0; c < CHANNELS; c++) begin
      pop[c] = loadOut && (grantCh == CH_BITS'(c));
    end
  end

  always_ff @(posedge clk) begin
    for (int c = 0; c < CHANNELS; c++) begin
      if (push[c]) mem[c][wrPtr[c]] <= dataIn[c*WIDTH +: WIDTH];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int c = 0; c < CHANNELS; c++) begin
        wrPtr[c] <= '0;
        rdPtr[c] <= '0;
        count[c] <= '0;
      end
      slowInputting <= '0;
      overflow      <= '0;
    end else begin
      for (int c = 0; c < CHANNELS; c++) begin
        if (push[c]) wrPtr[c] <= wrPtr[c] + 1'b1;
        if (pop[c])  rdPtr[c] <= rdPtr[c] + 1'b1;
        if (push[c] && !pop[c])      count[c] <= count[c] + 1'b1;
        else if (!push[c] && pop[c]) count[c] <= count[c] - 1'b1;
        if (dataInValid[c] && full[c]) overflow[c] <= 1'b1;
        // Between the thresholds the flag holds its previous value.
        if (count[c] >= HIGH_CNT)     slowInputting[c] <= 1'b1;
        else if (count[c] < LOW_CNT)  slowInputting[c] <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dataOutValid   <= 1'b0;
      dataOut        <= '0;
      dataOutChannel <= '0;
      lastGrant      <= CH_BITS'(CHANNELS - 1);
    end else if (loadOut) begin
      dataOutValid   <= 1'b1;
      dataOut        <= mem[grantCh][rdPtr[grantCh]];
      dataOutChannel <= grantCh;
      lastGrant      <= grantCh;
    end else if (dataOutReady) begin
      dataOutValid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_multi_channel_output_buffer.sv
// Directed and randomized checks of multi_channel_output_buffer against a
// queue-based reference model of the FIFOs, throttle flags and arbiter.
module tb_multi_channel_output_buffer;

  localparam int NCH = 4;
  localparam int DEP = 16;
  localparam int HI  = 12;
  localparam int LO  = 8;

  logic             clk;
  logic             rst_n;
  logic [NCH-1:0]   inValid;
  logic [63:0]      inData [NCH];
  logic [NCH*64-1:0] dataInBus;
  logic [NCH-1:0]   slowInputting;
  logic [NCH-1:0]   overflow;
  logic             ready;
  logic             dataOutValid;
  logic [63:0]      dataOut;
  logic [1:0]       dataOutChannel;

  int checks;
  int failures;

  logic [63:0] mq [NCH][$];
  int          mLast;
  bit          mValid;
  logic [63:0] mData;
  int          mCh;
  bit [NCH-1:0] mSlow;
  bit [NCH-1:0] mOvf;

  multi_channel_output_buffer #(
    .WIDTH(64), .CHANNELS(NCH), .DEPTH_LOG2(4), .SLOW_HIGH(HI), .SLOW_LOW(LO)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .dataInValid(inValid),
    .dataIn(dataInBus),
    .slowInputting(slowInputting),
    .overflow(overflow),
    .dataOutReady(ready),
    .dataOutValid(dataOutValid),
    .dataOut(dataOut),
    .dataOutChannel(dataOutChannel)
  );

  always #5 clk = ~clk;

  always_comb begin
    dataInBus = '0;
    for (int c = 0; c < NCH; c++) dataInBus[c*64 +: 64] = inData[c];
  end

  task automatic checkVal(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic modelReset();
    for (int c = 0; c < NCH; c++) mq[c].delete();
    mLast  = NCH - 1;
    mValid = 0;
    mData  = '0;
    mCh    = 0;
    mSlow  = '0;
    mOvf   = '0;
  endtask

  // One clock edge of the reference: occupancy is sampled before any pop or push.
  task automatic modelStep();
    int sz [NCH];
    bit found;
    int c;
    for (int i = 0; i < NCH; i++) begin
      sz[i] = mq[i].size();
      if (sz[i] >= HI)     mSlow[i] = 1'b1;
      else if (sz[i] < LO) mSlow[i] = 1'b0;
    end
    if (!mValid || ready) begin
      found = 0;
      for (int k = 0; k < NCH; k++) begin
        c = (mLast + 1 + k) % NCH;
        if (!found && sz[c] > 0) begin
          found = 1;
          mData = mq[c].pop_front();
          mCh   = c;
          mLast = c;
        end
      end
      mValid = found;
    end
    for (int i = 0; i < NCH; i++) begin
      if (inValid[i]) begin
        if (sz[i] < DEP) mq[i].push_back(inData[i]);
        else             mOvf[i] = 1'b1;
      end
    end
  endtask

  task automatic compareAll();
    checkVal("valid", 64'(dataOutValid), 64'(mValid));
    if (mValid) begin
      checkVal("data", dataOut, mData);
      checkVal("chan", 64'(dataOutChannel), 64'(mCh));
    end
    checkVal("slow", 64'(slowInputting), 64'(mSlow));
    checkVal("ovf", 64'(overflow), 64'(mOvf));
  endtask

  task automatic tick();
    @(posedge clk);
    if (rst_n) modelStep();
    #1;
    compareAll();
  endtask

  task automatic idle(input int n, input bit rdy);
    inValid = '0;
    ready   = rdy;
    for (int i = 0; i < n; i++) tick();
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    clk      = 0;
    rst_n    = 1;
    ready    = 0;
    inValid  = '0;
    for (int c = 0; c < NCH; c++) inData[c] = '0;
    modelReset();

    #2 rst_n = 0;
    #1;
    checkVal("rst_valid", 64'(dataOutValid), 64'd0);
    checkVal("rst_data", dataOut, 64'd0);
    checkVal("rst_chan", 64'(dataOutChannel), 64'd0);
    checkVal("rst_slow", 64'(slowInputting), 64'd0);
    checkVal("rst_ovf", 64'(overflow), 64'd0);
    repeat (2) tick();
    rst_n = 1;
    tick();

    // Order and latency on channel 2
    ready = 1;
    inValid = 4'b0100; inData[2] = 64'hA; tick();
    inData[2] = 64'hB; tick();
    checkVal("t1_first", dataOut, 64'hA);
    checkVal("t1_chan", 64'(dataOutChannel), 64'd2);
    inData[2] = 64'hC; tick();
    checkVal("t1_second", dataOut, 64'hB);
    inValid = '0; tick();
    checkVal("t1_third", dataOut, 64'hC);
    tick();
    checkVal("t1_drop", 64'(dataOutValid), 64'd0);

    // Fairness: two words per channel queued under backpressure
    ready = 0;
    for (int w = 0; w < 2; w++) begin
      inValid = 4'hF;
      for (int c = 0; c < NCH; c++) inData[c] = 64'(16 * c + w + 64'h100);
      tick();
    end
    idle(2, 0);
    idle(10, 1);

    // Backpressure while writes continue
    ready = 0;
    for (int i = 0; i < 10; i++) begin
      inValid = 4'($urandom_range(0, 15));
      for (int c = 0; c < NCH; c++) inData[c] = {$urandom, $urandom};
      tick();
    end
    idle(60, 1);

    // Hysteresis on channel 1
    ready = 0;
    inValid = 4'b0010;
    for (int i = 0; i < 13; i++) begin
      inData[1] = 64'(64'h200 + i);
      tick();
    end
    inValid = '0;
    checkVal("t4_notYet", 64'(slowInputting[1]), 64'd0);
    tick();
    checkVal("t4_set", 64'(slowInputting[1]), 64'd1);
    idle(20, 1);
    checkVal("t4_clear", 64'(slowInputting[1]), 64'd0);

    // Overflow on channel 3
    ready = 0;
    inValid = 4'b1000;
    for (int i = 0; i < 18; i++) begin
      inData[3] = 64'(64'h300 + i);
      tick();
    end
    checkVal("t5_ovf", 64'(overflow), 64'h8);
    idle(25, 1);
    checkVal("t5_sticky", 64'(overflow), 64'h8);

    // Reset mid-stream
    ready = 0;
    inValid = 4'b0110;
    for (int i = 0; i < 5; i++) begin
      inData[1] = {$urandom, $urandom};
      inData[2] = {$urandom, $urandom};
      tick();
    end
    inValid = '0;
    rst_n = 0;
    #1;
    modelReset();
    checkVal("t6_valid", 64'(dataOutValid), 64'd0);
    checkVal("t6_data", dataOut, 64'd0);
    checkVal("t6_ovf", 64'(overflow), 64'd0);
    tick();
    tick();
    rst_n = 1;
    idle(3, 1);
    inValid = 4'b1001; inData[0] = 64'h55; inData[3] = 64'h66; tick();
    inValid = '0; tick();
    checkVal("t6_firstGrant", 64'(dataOutChannel), 64'd0);
    idle(4, 1);

    // Randomized traffic with bursty backpressure
    for (int i = 0; i < 3000; i++) begin
      inValid = 4'($urandom_range(0, 15)) & 4'($urandom_range(0, 15));
      for (int c = 0; c < NCH; c++) inData[c] = {$urandom, $urandom};
      ready = ((i / 200) % 2 == 0) ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 3) == 0);
      tick();
    end
    idle(80, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
